// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, widths, state codes and clip helper for the
// sprite blitter. Optional build macro used by this slice: SPRITE_BLIT_MIRROR_EN.
package sprite_pkg;

    // Sprite geometry and screen limits
    localparam int SPR_ROWS = 12;
    localparam int SPR_COLS = 18;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam logic [23:0] KEY_COLOUR = 24'hFF0096;

    // Field widths
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int ROW_W = 4;
    localparam int COL_W = 5;
    localparam int RGB_W = 24;

    // Clip limits widened by one bit so that pos + offset never wraps
    localparam logic [X_W:0] SCREEN_W_LIM = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] SCREEN_H_LIM = SCREEN_H[Y_W:0];

    // Blitter FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // True when the texel at (row, col) of a sprite placed at (x0, y0) lands on screen
    function automatic logic on_screen(input logic [X_W-1:0]   x0,
                                       input logic [Y_W-1:0]   y0,
                                       input logic [ROW_W-1:0] row,
                                       input logic [COL_W-1:0] col);
        logic [X_W:0] sx;
        logic [Y_W:0] sy;
        sx = {1'b0, x0} + {{(X_W + 1 - COL_W){1'b0}}, col};
        sy = {1'b0, y0} + {{(Y_W + 1 - ROW_W){1'b0}}, row};
        return (sx < SCREEN_W_LIM) && (sy < SCREEN_H_LIM);
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: raster texel counter (col fastest, then row), last-texel
// flag and horizontal mirroring of the issued ROM column.
module sprite_addr_gen
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             step,
    input  logic             flip,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [COL_W-1:0] addr_col,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPR_ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPR_COLS - 1);

    assign last     = (row == ROW_MAX) && (col == COL_MAX);
    // Screen position always follows the unmirrored column; only the ROM read flips
    assign addr_col = flip ? (COL_MAX - col) : col;

    // Raster counter: clear on a new blit, advance one texel per step, wrap after the last
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: walks a sprite ROM in raster order, absorbs the ROM's
// one-cycle read latency and streams opaque, on-screen pixels to the
// framebuffer writer. Optional build macro: SPRITE_BLIT_MIRROR_EN (adds flip_x).
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [X_W-1:0]   pos_x,
    input  logic [Y_W-1:0]   pos_y,
    input  logic [1:0]       frame_in,
`ifdef SPRITE_BLIT_MIRROR_EN
    input  logic             flip_x,
`endif
    output logic [1:0]       frame_sel,
    output logic [ROW_W-1:0] rom_row,
    output logic [COL_W-1:0] rom_col,
    input  logic [RGB_W-1:0] colour_in,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [X_W-1:0]   px_x,
    output logic [Y_W-1:0]   px_y,
    output logic [RGB_W-1:0] px_colour,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Pixel handshake: a pixel transfers on a rising edge where px_valid and
    // px_ready are both high. Once px_valid rises, px_x/px_y/px_colour and
    // px_valid hold until that transfer; px_valid never depends on px_ready.
    // The whole pipeline moves only when adv is high (output slot free or draining).

    logic [1:0]       state;
    logic             adv;
    logic             start_acc;
    logic [X_W-1:0]   pos_x_q;
    logic [Y_W-1:0]   pos_y_q;
    logic             flip_w;

    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic [COL_W-1:0] cnt_addr_col;
    logic             cnt_last;

    logic             s1_valid;
    logic [ROW_W-1:0] s1_row;
    logic [COL_W-1:0] s1_col;
    logic [ROW_W-1:0] s1_addr_row;
    logic [COL_W-1:0] s1_addr_col;

    assign adv       = !px_valid || px_ready;
    assign start_acc = (state == ST_IDLE) && start;
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

`ifdef SPRITE_BLIT_MIRROR_EN
    logic flip_q;

    // Mirror select is latched with the blit so it cannot change mid-sprite
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       flip_q <= 1'b0;
        else if (start_acc) flip_q <= flip_x;
    end
    assign flip_w = flip_q;
`else
    assign flip_w = 1'b0;
`endif

    sprite_addr_gen u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (start_acc),
        .step     ((state == ST_RUN) && adv),
        .flip     (flip_w),
        .row      (cnt_row),
        .col      (cnt_col),
        .addr_col (cnt_addr_col),
        .last     (cnt_last)
    );

    // ROM address mux: during a stall re-present the address the ROM already holds
    always_comb begin
        rom_row = s1_addr_row;
        rom_col = s1_addr_col;
        if (adv) begin
            rom_row = cnt_row;
            rom_col = cnt_addr_col;
        end
    end

    // Blit control FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start)              state <= ST_RUN;
                ST_RUN:   if (adv && cnt_last)    state <= ST_DRAIN;
                ST_DRAIN: if (!s1_valid && adv)   state <= ST_DONE;
                default:                          state <= ST_IDLE;
            endcase
        end
    end

    // Blit parameters sampled once per accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            frame_sel <= '0;
        end else if (start_acc) begin
            pos_x_q   <= pos_x;
            pos_y_q   <= pos_y;
            frame_sel <= frame_in;
        end
    end

    // Copy of the ROM's internal address register, so colour_in stays put through stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_addr_row <= '0;
            s1_addr_col <= '0;
        end else begin
            s1_addr_row <= rom_row;
            s1_addr_col <= rom_col;
        end
    end

    // Stage 1: tracks which texel colour_in belongs to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
        end else if (adv) begin
            s1_valid <= (state == ST_RUN);
            s1_row   <= cnt_row;
            s1_col   <= cnt_col;
        end
    end

    // Output register: keep opaque on-screen texels, drop the rest
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px_valid  <= 1'b0;
            px_x      <= '0;
            px_y      <= '0;
            px_colour <= '0;
        end else if (adv) begin
            px_valid  <= s1_valid && (colour_in != KEY_COLOUR)
                         && on_screen(pos_x_q, pos_y_q, s1_row, s1_col);
            px_x      <= pos_x_q + {{(X_W - COL_W){1'b0}}, s1_col};
            px_y      <= pos_y_q + {{(Y_W - ROW_W){1'b0}}, s1_row};
            px_colour <= colour_in;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized scoreboard bench for sprite_blitter with a
// registered ROM model, random backpressure and a list-based pixel reference.
`timescale 1ns/1ps
module tb_sprite_blitter;

    localparam int ROWS = 12;
    localparam int COLS = 18;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam logic [23:0] KEY = 24'hFF0096;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [8:0]  pos_y = '0;
    logic [1:0]  frame_in = '0;
    logic        px_ready = 1'b1;
    logic [23:0] colour_in;
    logic [1:0]  frame_sel;
    logic [3:0]  rom_row;
    logic [4:0]  rom_col;
    logic        px_valid;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic [23:0] px_colour;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;
`ifdef SPRITE_BLIT_MIRROR_EN
    logic        flip_x = 1'b0;
`endif

    always #5 clk = ~clk;

    sprite_blitter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .frame_in  (frame_in),
`ifdef SPRITE_BLIT_MIRROR_EN
        .flip_x    (flip_x),
`endif
        .frame_sel (frame_sel),
        .rom_row   (rom_row),
        .rom_col   (rom_col),
        .colour_in (colour_in),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_colour (px_colour),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- ROM model: one-cycle registered address ----------------
    logic [23:0] rom_mem [ROWS*COLS];
    logic [23:0] rom_q = '0;
    int          rom_idx;

    assign rom_idx   = int'(rom_row) * COLS + int'(rom_col);
    assign colour_in = rom_q;

    always @(posedge clk) begin
        rom_q <= (rom_idx < ROWS*COLS) ? rom_mem[rom_idx] : 24'h0;
    end

    // mode 0: random opaque, 1: cols 0..5 keyed, 2: unique colour per col, 3: ~25% keyed
    task automatic fill_rom(input int mode);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic [23:0] v;
                v = 24'($urandom);
                if (v == KEY) v = v ^ 24'h1;
                if (mode == 1 && c < 6) v = KEY;
                if (mode == 2) v = {8'hA5, 8'(c), 8'h3C};
                if (mode == 3 && $urandom_range(0, 3) == 0) v = KEY;
                rom_mem[r*COLS + c] = v;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [42:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int pix_cnt  = 0;
    bit mon_en   = 1'b0;
    int stall_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: list every sprite texel, keep opaque ones whose screen point is inside the screen
    task automatic build_expected(input int px, input int py, input bit flip);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int src;
                logic [23:0] col;
                src = flip ? (COLS - 1 - c) : c;
                col = rom_mem[r*COLS + src];
                if (col != KEY && (px + c) < SCR_W && (py + r) < SCR_H)
                    exp_q.push_back({10'(px + c), 9'(py + r), col});
            end
        end
    endtask

    // Monitor: pops on every handshake, checks hold/ROM-address stability during stalls
    initial begin
        logic        prev_stall;
        logic [42:0] prev_px;
        logic [8:0]  prev_addr;
        prev_stall = 1'b0;
        prev_px    = '0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n) begin
                if (prev_stall)
                    check("stall_px_hold", {px_valid, px_x, px_y, px_colour}, {1'b1, prev_px});
                if (px_valid && !px_ready)
                    check("stall_rom_addr", {rom_row, rom_col}, prev_addr);
                if (px_valid && px_ready) begin
                    pix_cnt++;
                    if (exp_q.size() == 0) check("unexpected_pixel", {px_x, px_y, px_colour}, 64'h0);
                    else check("pixel", {px_x, px_y, px_colour}, exp_q.pop_front());
                end
            end
            prev_stall = mon_en && reset_n && px_valid && !px_ready;
            prev_px    = {px_x, px_y, px_colour};
            prev_addr  = {rom_row, rom_col};
        end
    end

    // Backpressure driver: always ready, or random with occasional 5-cycle low holds
    initial begin
        int hold;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode == 0) px_ready = 1'b1;
            else if (hold > 0) hold--;
            else if ($urandom_range(0, 5) == 0) begin
                px_ready = 1'b0;
                hold = 4;
            end else px_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_start(input int px, input int py, input bit flip, input logic [1:0] frm);
        @(posedge clk);
        #1;
        pos_x = 10'(px);
        pos_y = 9'(py);
        frame_in = frm;
`ifdef SPRITE_BLIT_MIRROR_EN
        flip_x = flip;
`else
        if (flip) $display("flip requested without mirror build");
`endif
        start = 1'b1;
        @(posedge clk);  // E0
        #1;
        start = 1'b0;
        pos_x = 10'($urandom);
        pos_y = 9'($urandom);
        frame_in = ~frm;
    endtask

    task automatic run_blit(input string tag, input int px, input int py, input bit flip,
                            input int exp_count, input bit chk_lat, input int restart_at);
        int cyc;
        int dones;
        bit seen;
        logic [1:0] frm;
        frm = 2'($urandom);
        exp_q.delete();
        build_expected(px, py, flip);
        pix_cnt = 0;
        mon_en = 1'b1;
        issue_start(px, py, flip, frm);
        check({tag, "_busy_after_start"}, busy, 1);
        cyc = 0;
        if (chk_lat) begin
            check({tag, "_valid_E0"}, px_valid, 0);
            @(posedge clk); #1;
            check({tag, "_valid_E1"}, px_valid, 0);
            @(posedge clk); #1;
            check({tag, "_valid_E2"}, px_valid, 1);
            cyc = 2;
        end
        seen = 1'b0;
        dones = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                dones++;
                check({tag, "_busy_at_done"}, busy, 0);
                if (chk_lat) check({tag, "_done_cycle"}, cyc, 218);
            end
            if (cyc == 60) check({tag, "_frame_sel"}, frame_sel, frm);
            if (restart_at > 0 && cyc == restart_at) begin
                start = 1'b1;
                pos_x = 10'(px + 7);
                pos_y = 9'(py + 3);
            end
            cyc++;
        end
        check({tag, "_done_seen"}, seen, 1);
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        check({tag, "_done_once"}, dones, 1);
        if (exp_count >= 0) check({tag, "_pixel_count"}, pix_cnt, exp_count);
        check({tag, "_left_over"}, exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    task automatic reset_midblit();
        int dones;
        exp_q.delete();
        issue_start(123, 77, 1'b0, 2'b11);
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_outputs", {px_valid, px_x, px_y, px_colour, busy, done, frame_sel, rom_row, rom_col},
              64'h0);
        check("rst_state", state_dbg, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || px_valid || busy) dones++;
        end
        check("rst_no_done_after", dones, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {px_valid, px_x, px_y, px_colour, busy, done, frame_sel}, 64'h0);
        check("reset_rom_addr", {rom_row, rom_col}, 0);
        check("reset_state", state_dbg, 0);
        reset_n = 1'b1;

        fill_rom(0);
        stall_mode = 0;
        run_blit("full", 100, 50, 1'b0, 216, 1'b1, 0);
        stall_mode = 1;
        run_blit("stall", 100, 50, 1'b0, 216, 1'b0, 0);
        stall_mode = 0;

        fill_rom(1);
        run_blit("transp", 100, 50, 1'b0, 144, 1'b0, 0);

        fill_rom(0);
        run_blit("clip", 630, 475, 1'b0, 50, 1'b0, 0);
        stall_mode = 1;
        run_blit("clip_stall", 630, 475, 1'b0, 50, 1'b0, 0);

        for (int i = 0; i < 4; i++) begin
            fill_rom(3);
            run_blit("rand", $urandom_range(0, 1023), $urandom_range(0, 511), 1'b0, -1, 1'b0, 0);
        end

        stall_mode = 0;
        fill_rom(0);
        run_blit("restart", 100, 50, 1'b0, 216, 1'b0, 40);

        reset_midblit();
        run_blit("after_rst", 100, 50, 1'b0, 216, 1'b0, 0);

`ifdef SPRITE_BLIT_MIRROR_EN
        fill_rom(2);
        run_blit("mirror", 200, 100, 1'b1, 216, 1'b0, 0);
        stall_mode = 1;
        fill_rom(3);
        run_blit("mirror_rand", 630, 470, 1'b1, -1, 1'b0, 0);
        stall_mode = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Reader side of the sprite colour ROMs (e.g. flap animation frames, 12 rows x 18 cols, 24-bit RGB, one-cycle registered address).
- On a start command, walks every sprite texel in raster order and drives ROM row/col addresses. It absorbs the ROM's 1-cycle read latency.
- Drops transparent and off-screen texels and streams opaque pixels with screen coordinates to the framebuffer writer over a valid/ready handshake.
- Sits between the game-state FSM (bird position and frame select) and the framebuffer write port.

Parameters:
- SPR_ROWS, 12, sprite height in texels
- SPR_COLS, 18, sprite width in texels
- SCREEN_W, 640, horizontal clip limit in pixels
- SCREEN_H, 480, vertical clip limit in pixels
- KEY_COLOUR, 24'hFF0096, transparent colour key

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to blit; honoured only in IDLE
- pos_x  in  10  screen x of sprite top-left, sampled on accepted start
- pos_y  in  9  screen y of sprite top-left, sampled on accepted start
- frame_in  in  2  animation frame select, sampled on accepted start
- frame_sel  out  2  latched frame; drives the external ROM output mux
- rom_row  out  4  ROM row address
- rom_col  out  5  ROM column address
- colour_in  in  24  ROM colour_data; corresponds to the address presented on the previous edge
- px_valid  out  1  output pixel valid
- px_ready  in  1  framebuffer accepts pixel
- px_x  out  10  pixel screen x
- px_y  out  9  pixel screen y
- px_colour  out  24  pixel RGB
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse after the last opaque pixel is accepted

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; address counters 0; stage-1 valid 0.
  - Reset mid-blit aborts immediately. No done pulse is produced and no pending pixel is retained.
- Advance condition: adv = !px_valid || px_ready.
- ROM address mux (combinational):
  - When adv = 1, rom_row/rom_col = next-texel counter.
  - When adv = 0, rom_row/rom_col = stage-1 address register.
  - The stage-1 register loads rom_row/rom_col on every edge, so it always mirrors the ROM's internal address register. This keeps colour_in stable through any stall.
- Texel order and counter:
  - Raster order: col 0..SPR_COLS-1 within row, then row 0..SPR_ROWS-1.
  - Counter wraps col to 0 and increments row at col = SPR_COLS-1.
  - Counter advances only when adv = 1 and in RUN.
- Stage 1 (colour_in valid):
  - Pixel is opaque if colour_in != KEY_COLOUR.
  - Pixel is on-screen if pos_x + col < SCREEN_W and pos_y + row < SCREEN_H. Sums use 11-bit and 10-bit widths respectively, so they never wrap.
  - On adv, px_valid <= stage-1 valid and opaque and on-screen. px_x, px_y and px_colour load alongside.
  - Dropped texels consume one cycle each and emit nothing.
- Output holding: px_* stay stable while px_valid = 1 and px_ready = 0.
- State machine:
  - IDLE: start -> latch pos/frame, counter = 0, go RUN. busy = 1 from the next cycle.
  - RUN: issue addresses. After the last texel (row SPR_ROWS-1, col SPR_COLS-1) is issued with adv = 1, go DRAIN.
  - DRAIN: wait until stage 1 is empty and (px_valid = 0 or px_ready = 1). Then go DONE.
  - DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- start while busy is ignored.
- frame_sel is constant for the whole blit.
- Latency: start sampled at edge E0; first opaque pixel px_valid at E2.
- Throughput: 1 texel per cycle when px_ready stays high. A full blit takes 216 texel cycles plus 3.

Optional Feature:
- Macro: SPRITE_BLIT_MIRROR_EN.
- When defined:
  - Extra input flip_x (1 bit), sampled with start.
  - When flip_x = 1, the issued rom_col = SPR_COLS-1-col. The screen x still uses the unmirrored col, giving a horizontally flipped sprite.
- When undefined: port absent; no mirroring.

Decomposition:
- Shared package sprite_pkg:
  - SPR_ROWS, SPR_COLS, KEY_COLOUR, SCREEN_W, SCREEN_H.
  - Pixel coordinate widths.
  - State enum (IDLE, RUN, DRAIN, DONE).
- One natural sub-module: sprite_addr_gen, holding the raster counter, last-texel flag and mirror logic. The pipeline/handshake stays in the top.

Test Plan:
- Full blit, no stall: px_ready = 1, pos = (100,50), all-opaque ROM model -> 216 pixels, first at (100,50), last at (117,61), px_valid first high 2 cycles after start, done pulse once.
- Transparency: ROM model returns 24'hFF0096 for col < 6 on every row -> exactly 144 pixels, none with x < 106.
- Backpressure: toggle px_ready 0/1 randomly, including 5-cycle low holds -> pixel sequence identical to the no-stall run. rom_row/rom_col equal the stage-1 address throughout each stall. px_* stable while stalled.
- Clipping: pos = (630,475) -> only pixels with x <= 639 and y <= 479 emitted (10 cols x 5 rows = 50 if opaque); done still asserts.
- Start while busy / reset mid-blit: second start at texel 40 is ignored (216 total). reset_n low at texel 100 -> all outputs 0 next cycle, no done pulse; a fresh start then blits normally.
- Mirror (macro defined, flip_x = 1): ROM model with a unique colour per col -> pixel at x = pos_x + 0 carries the col-17 colour.
